fft_seq_ctrl: RTL
=================

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter points, default 64, FFT size in complex points (power of two, >=4).
REQ-002 SHALL have parameter logpoints, default 6, log2(points).
REQ-003 SHALL have parameter bf_latency, default 4, butterfly read-to-writeback latency in ce-enabled cycles (>=1).
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-low reset.
REQ-006 SHALL have port ce  input  1  clock enable; when 0, all state holds.
REQ-007 SHALL have port start  input  1  request one in-place FFT pass over the working RAM.
REQ-008 SHALL have port busy  output  1  high from the first cycle after start acceptance through the done cycle.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port bf_valid  output  1  read pair issued this cycle.
REQ-011 SHALL have ports addr_a, addr_b  output  logpoints each  read addresses of the butterfly pair.
REQ-012 SHALL have port tw_addr  output  logpoints-1  twiddle ROM index.
REQ-013 SHALL have port stage  output  $clog2(logpoints)  current stage number, 0..logpoints-1.
REQ-014 SHALL have port wb_valid  output  1  write back butterfly results this cycle.
REQ-015 SHALL have ports wb_addr_a, wb_addr_b  output  logpoints each  write-back addresses.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE; every output SHALL be registered.
REQ-017 IDLE: on start=1 with ce=1, SHALL go to RUN with stage=0 and pair index k=0.
REQ-018 RUN: SHALL issue one pair per ce cycle, k=0..points/2-1, with bf_valid=1.
REQ-019 Address rule for stage s: h=points>>(s+1), pos=k mod h, grp=k/h; addr_a=2*h*grp+pos; addr_b=addr_a+h; tw_addr=pos<<s (truncated to logpoints-1 bits).
REQ-020 After k=points/2-1 issues, SHALL enter DRAIN for exactly bf_latency ce cycles with bf_valid=0.
REQ-021 At DRAIN end: if stage<logpoints-1, SHALL increment stage, reset k=0, and return to RUN; otherwise SHALL go to DONE.
REQ-022 DONE: SHALL hold done=1 and busy=1 for one cycle, then return to IDLE with done=0 and busy=0.
REQ-023 SHALL feed addr_a, addr_b and bf_valid through a bf_latency-deep delay line. wb_valid, wb_addr_a and wb_addr_b SHALL equal the issue-side values from bf_latency ce cycles earlier.
REQ-024 No read of stage s+1 SHALL occur before the final write-back of stage s (guaranteed by REQ-020).
REQ-025 start SHALL be ignored while busy=1 or in DONE; no queuing.
REQ-026 When ce=0, state, counters and the delay line SHALL hold; bf_valid and wb_valid SHALL output 0; the address outputs SHALL hold.
REQ-027 The pass SHALL take logpoints*(points/2+bf_latency)+1 ce cycles from the first bf_valid to done inclusive.

Reset
REQ-028 On RST=0 at a clock edge, SHALL enter IDLE with busy, done, bf_valid and wb_valid at 0; addr_a, addr_b, tw_addr, stage, wb_addr_a, wb_addr_b, k and the delay line at 0.
REQ-029 Reset mid-pass SHALL abort immediately; no wb_valid SHALL appear after reset deasserts until the next start.
REQ-030 Reset SHALL take priority over ce and start.

Verification
REQ-031 Defaults, ce=1, start pulse at edge 0 -> cycle 1: bf_valid=1, addr_a=0, addr_b=32, tw_addr=0; cycle 32: addr_a=31, addr_b=63, tw_addr=31.
REQ-032 Same run -> cycle 37: stage=1, addr_a=0, addr_b=16; cycle 52 (k=15): addr_a=15, addr_b=31, tw_addr=30; cycle 53 (k=16): addr_a=32, addr_b=48, tw_addr=0.
REQ-033 Same run -> stage 5: k=0 gives addr_a=0, addr_b=1, tw_addr=0; k=31 at cycle 212 gives addr_a=62, addr_b=63; wb_valid last high at cycle 216; done=1 only at cycle 217; busy low at cycle 218.
REQ-034 Every bf_valid cycle c with addresses (a,b) -> wb_valid at c+4 with wb_addr_a=a, wb_addr_b=b; exactly 192 wb_valid pulses per pass.
REQ-035 ce=0 for 10 cycles mid-stage-2, plus a start pulse during the run -> no bf_valid or wb_valid during the stall, done delayed by exactly 10 cycles, second start has no effect.
REQ-036 RST=0 for one cycle at cycle 100 -> next cycle: busy=0, bf_valid=0, wb_valid=0, stage=0; no wb_valid until a new start is applied.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// Address/control sequencer for an in-place radix-2 FFT over a single working RAM.
// Issues butterfly read pairs stage by stage and replays them as write-backs after bf_latency.
module fft_seq_ctrl #(
  parameter int points     = 64,
  parameter int logpoints  = 6,
  parameter int bf_latency = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         ce,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         bf_valid,
  output logic [logpoints-1:0]         addr_a,
  output logic [logpoints-1:0]         addr_b,
  output logic [logpoints-2:0]         tw_addr,
  output logic [$clog2(logpoints)-1:0] stage,
  output logic                         wb_valid,
  output logic [logpoints-1:0]         wb_addr_a,
  output logic [logpoints-1:0]         wb_addr_b
);

  localparam int AW = logpoints;
  localparam int KW = logpoints - 1;
  localparam int SW = $clog2(logpoints);
  localparam int DW = $clog2(bf_latency + 1);

  localparam logic [KW-1:0] K_LAST = KW'(points / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(logpoints - 1);
  localparam logic [DW-1:0] D_LAST = DW'(bf_latency - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } pair_t;

  state_t              state, state_n;
  logic [KW-1:0]       k, k_n;
  logic [SW-1:0]       stg_n;
  logic [DW-1:0]       dcnt, dcnt_n;
  logic                iss_n, busy_n, done_n;

  // Index 0 is the issue side (drives addr_a/addr_b), index bf_latency the write-back side.
  pair_t [bf_latency:0]  pr_pipe;
  logic  [bf_latency-1:0] vld_pipe;

  pair_t               pr_n;
  logic [KW-1:0]       tw_n;
  logic [AW-1:0]       kk, msk, hb, pos;

  assign addr_a    = pr_pipe[0].a;
  assign addr_b    = pr_pipe[0].b;
  assign wb_addr_a = pr_pipe[bf_latency].a;
  assign wb_addr_b = pr_pipe[bf_latency].b;

  // Pair k of stage s: the low (KW-s) bits of k are the position inside a group, the rest
  // select the group; inserting a zero bit between them gives addr_a, setting it gives addr_b.
  always_comb begin
    kk     = {1'b0, k_n};
    hb     = AW'(1) << (KW - 32'(stg_n));
    msk    = hb - AW'(1);
    pos    = kk & msk;
    pr_n.a = ((kk & ~msk) << 1) | pos;
    pr_n.b = pr_n.a | hb;
    tw_n   = pos[KW-1:0] << stg_n;
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    stg_n   = stage;
    dcnt_n  = dcnt;
    iss_n   = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n = RUN;
          k_n     = '0;
          stg_n   = '0;
          iss_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        if (k == K_LAST) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end else begin
          k_n   = k + 1'b1;
          iss_n = 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == D_LAST) begin
          if (stage == S_LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RUN;
            stg_n   = stage + 1'b1;
            k_n     = '0;
            iss_n   = 1'b1;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      k        <= '0;
      stage    <= '0;
      dcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bf_valid <= 1'b0;
      wb_valid <= 1'b0;
      tw_addr  <= '0;
      vld_pipe <= '0;
      pr_pipe  <= '0;
    end else if (ce) begin
      state    <= state_n;
      k        <= k_n;
      stage    <= stg_n;
      dcnt     <= dcnt_n;
      busy     <= busy_n;
      done     <= done_n;
      bf_valid <= iss_n;
      wb_valid <= vld_pipe[bf_latency-1];
      vld_pipe[0] <= iss_n;
      for (int i = 1; i < bf_latency; i++) vld_pipe[i] <= vld_pipe[i-1];
      for (int i = 1; i <= bf_latency; i++) pr_pipe[i] <= pr_pipe[i-1];
      // Addresses hold across drain so the RAM port sees no spurious toggling.
      if (iss_n) begin
        pr_pipe[0] <= pr_n;
        tw_addr    <= tw_n;
      end
    end else begin
      // Stalled: everything holds, but no strobe may be seen twice.
      bf_valid <= 1'b0;
      wb_valid <= 1'b0;
    end
  end

endmodule
